// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding, forwarding-select codes,
//                bubble opcode and the forwarding priority helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_BR_FLUSH = 2'd3
    } state_t;

    // Operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // ALU opcode loaded into decode->EX/MEM when a bubble is inserted
    localparam logic [4:0] OP_ALU_PASSB = 5'b10011;

    // EX/MEM result beats WB result; a load in EX/MEM has no result yet
    function automatic logic [1:0] fwd_select(
        input logic i_use,
        input logic i_exm_hit,
        input logic i_exm_load,
        input logic i_wb_hit
    );
        logic [1:0] w_sel;
        w_sel = FWD_RF;
        if (i_use && i_exm_hit && !i_exm_load) begin
            w_sel = FWD_EXM;
        end else if (i_use && i_wb_hit) begin
            w_sel = FWD_WB;
        end
        return w_sel;
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Bundle of decode / EX/MEM / WB status inputs and the
//                enable, flush, forwarding and statistics outputs of the
//                hazard controller. slave = controller, master = pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int RW    = 4,
    parameter int CNT_W = 16
);
    logic [RW-1:0]    id_ra;
    logic [RW-1:0]    id_rb;
    logic             id_use_ra;
    logic             id_use_rb;
    logic [RW-1:0]    exm_wc;
    logic             exm_wr;
    logic             exm_load;
    logic             exm_mem_req;
    logic             dm_ready;
    logic [RW-1:0]    wb_wc;
    logic             wb_wr;
    logic             br_taken;

    logic             en_pc;
    logic             en_ifid;
    logic             en_idex;
    logic             flush_ifid;
    logic             flush_idex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_ra, id_rb, id_use_ra, id_use_rb,
        input  exm_wc, exm_wr, exm_load, exm_mem_req, dm_ready,
        input  wb_wc, wb_wr, br_taken,
        output en_pc, en_ifid, en_idex, flush_ifid, flush_idex,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport master (
        output id_ra, id_rb, id_use_ra, id_use_rb,
        output exm_wc, exm_wr, exm_load, exm_mem_req, dm_ready,
        output wb_wc, wb_wr, br_taken,
        input  en_pc, en_ifid, en_idex, flush_ifid, flush_idex,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Combinational register-index comparison producing the
//                operand forwarding selects and the load-use hazard flag.
//                Register index 0 is treated like any other index.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int RW = 4
) (
    input  wire logic [RW-1:0] i_id_ra,
    input  wire logic [RW-1:0] i_id_rb,
    input  wire logic          i_id_use_ra,
    input  wire logic          i_id_use_rb,
    input  wire logic [RW-1:0] i_exm_wc,
    input  wire logic          i_exm_wr,
    input  wire logic          i_exm_load,
    input  wire logic [RW-1:0] i_wb_wc,
    input  wire logic          i_wb_wr,
    output logic [1:0]         o_fwd_a,
    output logic [1:0]         o_fwd_b,
    output logic               o_load_use
);

    logic w_exm_hit_a;
    logic w_exm_hit_b;
    logic w_wb_hit_a;
    logic w_wb_hit_b;

    // Index matches against writers in EX/MEM and WB, then priority select
    always_comb begin
        w_exm_hit_a = i_exm_wr && (i_exm_wc == i_id_ra);
        w_exm_hit_b = i_exm_wr && (i_exm_wc == i_id_rb);
        w_wb_hit_a  = i_wb_wr  && (i_wb_wc  == i_id_ra);
        w_wb_hit_b  = i_wb_wr  && (i_wb_wc  == i_id_rb);
        o_fwd_a     = fwd_select(i_id_use_ra, w_exm_hit_a, i_exm_load, w_wb_hit_a);
        o_fwd_b     = fwd_select(i_id_use_rb, w_exm_hit_b, i_exm_load, w_wb_hit_b);
        // Loaded data is not available until WB, so a used match must stall
        o_load_use  = i_exm_load && ((i_id_use_ra && w_exm_hit_a) ||
                                     (i_id_use_rb && w_exm_hit_b));
    end

endmodule : hazard_fwd_unit
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Pipeline sequencing controller. Drives PC / IF/ID /
//                decode->EX/MEM enables and flushes, handles load-use
//                stalls, data-memory wait states and taken-branch flushes,
//                and selects operand forwarding.
//                Optional macro HAZARD_STATS_EN adds saturating stall and
//                flush cycle counters; without it both outputs read zero.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RW     = 4,
    parameter int BR_PEN = 2,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    // Cycles still to flush after the one in which the branch is seen
    localparam logic [2:0] C_BR_RELOAD = 3'(BR_PEN - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_br_cnt;
    logic [2:0] w_br_cnt_next;

    logic       w_en_front;
    logic       w_en_idex;
    logic       w_flush_ifid;
    logic       w_flush_idex;
    logic       w_decode;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_load_use;

    hazard_fwd_unit #(
        .RW (RW)
    ) u_fwd (
        .i_id_ra     (bus.id_ra),
        .i_id_rb     (bus.id_rb),
        .i_id_use_ra (bus.id_use_ra),
        .i_id_use_rb (bus.id_use_rb),
        .i_exm_wc    (bus.exm_wc),
        .i_exm_wr    (bus.exm_wr),
        .i_exm_load  (bus.exm_load),
        .i_wb_wc     (bus.wb_wc),
        .i_wb_wr     (bus.wb_wr),
        .o_fwd_a     (w_fwd_a),
        .o_fwd_b     (w_fwd_b),
        .o_load_use  (w_load_use)
    );

    // State and branch flush counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_br_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_br_cnt <= w_br_cnt_next;
        end
    end

    // Next-state and enable/flush decode
    always_comb begin
        w_state_next  = r_state;
        w_br_cnt_next = r_br_cnt;
        w_en_front    = 1'b1;
        w_en_idex     = 1'b1;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_decode      = 1'b0;

        if (!rst_n) begin
            w_en_front    = 1'b0;
            w_en_idex     = 1'b0;
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_state_next  = ST_RUN;
            w_br_cnt_next = 3'd0;
        end else begin
            case (r_state)
                ST_BR_FLUSH: begin
                    w_flush_ifid = 1'b1;
                    w_flush_idex = 1'b1;
                    if (bus.br_taken) begin
                        w_br_cnt_next = C_BR_RELOAD;
                        w_state_next  = (C_BR_RELOAD == 3'd0) ? ST_RUN : ST_BR_FLUSH;
                    end else if (r_br_cnt <= 3'd1) begin
                        w_br_cnt_next = 3'd0;
                        w_state_next  = ST_RUN;
                    end else begin
                        w_br_cnt_next = r_br_cnt - 3'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    // The completing cycle runs normally, so a held branch acts here
                    if (bus.dm_ready) begin
                        w_decode = 1'b1;
                    end else begin
                        w_en_front = 1'b0;
                        w_en_idex  = 1'b0;
                    end
                end
                default: begin
                    // LD_STALL marks the one cycle after a bubble; it runs like RUN
                    w_decode = 1'b1;
                end
            endcase

            if (w_decode) begin
                w_state_next = ST_RUN;
                if (bus.exm_mem_req && !bus.dm_ready) begin
                    w_en_front   = 1'b0;
                    w_en_idex    = 1'b0;
                    w_state_next = ST_MEM_WAIT;
                end else if (bus.br_taken) begin
                    w_flush_ifid  = 1'b1;
                    w_flush_idex  = 1'b1;
                    w_br_cnt_next = C_BR_RELOAD;
                    w_state_next  = (C_BR_RELOAD == 3'd0) ? ST_RUN : ST_BR_FLUSH;
                end else if (w_load_use) begin
                    w_en_front   = 1'b0;
                    w_flush_idex = 1'b1;
                    w_state_next = ST_LD_STALL;
                end
            end
        end
    end

    assign bus.en_pc      = w_en_front;
    assign bus.en_ifid    = w_en_front;
    assign bus.en_idex    = w_en_idex;
    assign bus.flush_ifid = w_flush_ifid;
    assign bus.flush_idex = w_flush_idex;
    assign bus.fwd_a      = rst_n ? w_fwd_a : FWD_RF;
    assign bus.fwd_b      = rst_n ? w_fwd_b : FWD_RF;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of stalled and bubbled cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (!w_en_front && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (w_flush_idex && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. A cycle
//                model tracks an outstanding memory access and the number
//                of branch flush cycles left, and predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int RW     = 4;
    localparam int BR_PEN = 2;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.RW(RW), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .RW     (RW),
        .BR_PEN (BR_PEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {en_pc, en_ifid, en_idex, flush_ifid, flush_idex, fwd_a, fwd_b}
    logic [8:0] w_obs;
    assign w_obs = {bus.en_pc, bus.en_ifid, bus.en_idex, bus.flush_ifid,
                    bus.flush_idex, bus.fwd_a, bus.fwd_b};

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [8:0]       e_vec;
    logic [CNT_W-1:0] e_stall;
    logic [CNT_W-1:0] e_flush;

    // Model state: pending memory access, flush cycles left, cycle counts
    bit               m_wait     = 1'b0;
    int               m_br_left  = 0;
    logic [CNT_W-1:0] m_stall    = '0;
    logic [CNT_W-1:0] m_flush    = '0;

    function automatic logic [1:0] ref_fwd(input logic use_r, input logic [RW-1:0] idx);
        if (use_r && bus.exm_wr && !bus.exm_load && bus.exm_wc == idx) return 2'b01;
        if (use_r && bus.wb_wr && bus.wb_wc == idx)                    return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic ref_load_use();
        return bus.exm_load && bus.exm_wr &&
               ((bus.id_use_ra && bus.exm_wc == bus.id_ra) ||
                (bus.id_use_rb && bus.exm_wc == bus.id_rb));
    endfunction

    // Predict this cycle's outputs from current inputs and model state
    task automatic model_eval();
        logic [4:0] ctl;
        if (!rst_n) begin
            ctl = 5'b00011;
        end else if (m_br_left > 0) begin
            ctl = 5'b11111;
        end else if (m_wait && !bus.dm_ready) begin
            ctl = 5'b00000;
        end else if (bus.exm_mem_req && !bus.dm_ready) begin
            ctl = 5'b00000;
        end else if (bus.br_taken) begin
            ctl = 5'b11111;
        end else if (ref_load_use()) begin
            ctl = 5'b00101;
        end else begin
            ctl = 5'b11100;
        end
        if (!rst_n) e_vec = {ctl, 4'b0000};
        else        e_vec = {ctl, ref_fwd(bus.id_use_ra, bus.id_ra), ref_fwd(bus.id_use_rb, bus.id_rb)};
`ifdef HAZARD_STATS_EN
        e_stall = m_stall;
        e_flush = m_flush;
`else
        e_stall = '0;
        e_flush = '0;
`endif
    endtask

    // Advance the model across the clock edge
    task automatic model_commit();
        if (!rst_n) begin
            m_wait = 1'b0; m_br_left = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!e_vec[8] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (e_vec[4]  && m_flush != '1) m_flush = m_flush + 1'b1;
            if (m_br_left > 0) begin
                m_br_left = bus.br_taken ? BR_PEN - 1 : m_br_left - 1;
            end else if (m_wait && !bus.dm_ready) begin
                m_wait = 1'b1;
            end else if (bus.exm_mem_req && !bus.dm_ready) begin
                m_wait = 1'b1;
            end else begin
                m_wait = 1'b0;
                if (bus.br_taken) m_br_left = BR_PEN - 1;
            end
        end
    endtask

    task automatic set_idle();
        bus.id_ra = '0; bus.id_rb = '0; bus.id_use_ra = 0; bus.id_use_rb = 0;
        bus.exm_wc = '0; bus.exm_wr = 0; bus.exm_load = 0; bus.exm_mem_req = 0;
        bus.dm_ready = 1; bus.wb_wc = '0; bus.wb_wr = 0; bus.br_taken = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_n = (i == 2);
            set_idle();
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL reset_ctl cyc%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.stall_cnt !== e_stall || bus.flush_cnt !== e_flush) begin
                n_fail++; $display("FAIL reset_cnt cyc%0d: got %0d/%0d expected %0d/%0d",
                                   i, bus.stall_cnt, bus.flush_cnt, e_stall, e_flush);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            bus.exm_wr = (i != 2); bus.exm_wc = 4'd3; bus.id_ra = 4'd3; bus.id_use_ra = 1;
            bus.wb_wr = (i != 0);  bus.wb_wc = 4'd3;
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL fwd_ctl step%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.fwd_a !== ((i == 2) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL fwd_a step%0d: got %b expected %b",
                                   i, bus.fwd_a, (i == 2) ? 2'b10 : 2'b01);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 2; i++) begin
            set_idle();
            bus.id_rb = 4'd5; bus.id_use_rb = 1; bus.id_ra = 4'd1; bus.id_use_ra = 1;
            if (i == 0) begin
                bus.exm_load = 1; bus.exm_wr = 1; bus.exm_wc = 4'd5;
            end else begin
                bus.wb_wr = 1; bus.wb_wc = 4'd5;
            end
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL load_use_ctl step%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.stall_cnt !== e_stall || bus.flush_cnt !== e_flush) begin
                n_fail++; $display("FAIL load_use_cnt step%0d: got %0d/%0d expected %0d/%0d",
                                   i, bus.stall_cnt, bus.flush_cnt, e_stall, e_flush);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            bus.exm_mem_req = (i < 4);
            bus.dm_ready    = (i >= 3);
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL mem_wait_ctl cyc%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.stall_cnt !== e_stall) begin
                n_fail++; $display("FAIL mem_wait_cnt cyc%0d: got %0d expected %0d", i, bus.stall_cnt, e_stall);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            if (i == 0) begin
                bus.br_taken = 1;
                bus.exm_load = 1; bus.exm_wr = 1; bus.exm_wc = 4'd7;
                bus.id_ra = 4'd7; bus.id_use_ra = 1;
            end
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL branch_ctl cyc%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.flush_cnt !== e_flush) begin
                n_fail++; $display("FAIL branch_cnt cyc%0d: got %0d expected %0d", i, bus.flush_cnt, e_flush);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            bus.exm_mem_req = (i < 3);
            bus.dm_ready    = (i >= 3);
            rst_n           = (i != 2);
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL reset_mid_ctl cyc%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.stall_cnt !== e_stall || bus.flush_cnt !== e_flush) begin
                n_fail++; $display("FAIL reset_mid_cnt cyc%0d: got %0d/%0d expected %0d/%0d",
                                   i, bus.stall_cnt, bus.flush_cnt, e_stall, e_flush);
            end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n           = ($urandom_range(0, 49) != 0);
            bus.id_ra       = 4'($urandom_range(0, 3));
            bus.id_rb       = 4'($urandom_range(0, 3));
            bus.id_use_ra   = 1'($urandom);
            bus.id_use_rb   = 1'($urandom);
            bus.exm_wc      = 4'($urandom_range(0, 3));
            bus.exm_wr      = 1'($urandom);
            bus.exm_load    = ($urandom_range(0, 2) == 0);
            bus.exm_mem_req = ($urandom_range(0, 3) == 0);
            bus.dm_ready    = 1'($urandom);
            bus.wb_wc       = 4'($urandom_range(0, 3));
            bus.wb_wr       = 1'($urandom);
            bus.br_taken    = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            model_eval();
            n_tests++;
            if (w_obs !== e_vec) begin
                n_fail++; $display("FAIL random_ctl cyc%0d: got %b expected %b", i, w_obs, e_vec);
            end
            n_tests++;
            if (bus.stall_cnt !== e_stall || bus.flush_cnt !== e_flush) begin
                n_fail++; $display("FAIL random_cnt cyc%0d: got %0d/%0d expected %0d/%0d",
                                   i, bus.stall_cnt, bus.flush_cnt, e_stall, e_flush);
            end
            @(posedge clk); model_commit(); #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        @(posedge clk); model_commit(); #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
